// File: rtl/mmul_pkg.sv
// -----------------------------------------------------------------------------
// mmul_pkg
// Shared definitions for the matrix-multiplier slice: the PE sequencer state
// encoding, datapath widths and default sizing parameters.
//
// Contents:
//   seq_state_t      - sequencer FSM states
//   DATA_W           - signed operand width fed to each PE
//   ACC_W            - signed PE accumulator / result width
//   PE_LATENCY       - edges from the PE sampling ready to done becoming visible
//   DEFAULT_DEPTH    - default maximum operand pairs per job
//   DEFAULT_TIMEOUT  - default WAIT cycles tolerated before a job is aborted
// -----------------------------------------------------------------------------
package mmul_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        FINISH = 3'd5
    } seq_state_t;

    localparam int DATA_W          = 8;
    localparam int ACC_W           = 23;
    localparam int PE_LATENCY      = 9;
    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/pe_dot_sequencer.sv
// -----------------------------------------------------------------------------
// pe_dot_sequencer
// Drives one signed shift-add processing element through a dot product of up
// to DEPTH operand pairs. A job clears the PE accumulator, then for every pair
// reads the operand buffer, hands the operands to the PE with a one-cycle
// ready strobe and waits for the PE done pulse. The final accumulator value is
// latched into result and announced with a one-cycle result_valid strobe.
// A job with an out-of-range length, or a PE that stops answering, produces a
// one-cycle err strobe instead.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   job request, only looked at while idle
//   len          in   number of operand pairs, captured with start
//   busy         out  high whenever a job is in progress
//   mem_addr     out  registered operand buffer read address
//   a_data       in   operand A, valid the cycle after mem_addr
//   b_data       in   operand B, valid the cycle after mem_addr
//   pe_rst       out  clears the PE accumulator
//   pe_ready     out  one-cycle issue strobe to the PE
//   pe_data1     out  operand A while pe_ready, otherwise 0
//   pe_data2     out  operand B while pe_ready, otherwise 0
//   pe_done      in   one-cycle PE completion pulse
//   pe_result    in   PE accumulator value
//   result       out  latched dot product
//   result_valid out  one-cycle strobe, result just updated
//   err          out  one-cycle strobe, bad length or PE timeout
// -----------------------------------------------------------------------------
import mmul_pkg::*;

module pe_dot_sequencer #(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              pe_rst,
    output logic              pe_ready,
    output logic [DATA_W-1:0] pe_data1,
    output logic [DATA_W-1:0] pe_data2,
    input  logic              pe_done,
    input  logic [ACC_W-1:0]  pe_result,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              err
);

    localparam int                WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    seq_state_t        state;
    seq_state_t        state_next;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic [WD_W-1:0]   watchdog;
    logic              err_q;
    logic              abort_q;

    logic              last_pair;
    logic              start_job;
    logic              empty_job;
    logic              bad_len;
    logic              next_pair;
    logic              final_pair;
    logic              timed_out;

    // The pair currently in flight is the last one when idx+1 reaches the
    // captured length; widening idx avoids wrap-around at idx == DEPTH-1.
    assign last_pair = (({1'b0, idx} + (ADDR_W + 1)'(1)) == len_q);

    // State register only; all sequencing decisions live in the block below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. Besides the next state this produces single-cycle
    // event flags that the datapath register block acts on, so every decision
    // is made in exactly one place. pe_done is only consulted in WAIT, which
    // keeps an undriven or stale done line from disturbing any other state.
    always_comb begin
        state_next = state;
        start_job  = 1'b0;
        empty_job  = 1'b0;
        bad_len    = 1'b0;
        next_pair  = 1'b0;
        final_pair = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        empty_job  = 1'b1;
                        state_next = FINISH;
                    end else if (len > DEPTH_L) begin
                        bad_len    = 1'b1;
                    end else begin
                        start_job  = 1'b1;
                        state_next = CLEAR;
                    end
                end
            end
            CLEAR:  state_next = FETCH;
            FETCH:  state_next = ISSUE;
            ISSUE:  state_next = WAIT;
            WAIT: begin
                if (pe_done) begin
                    if (last_pair) begin
                        final_pair = 1'b1;
                        state_next = FINISH;
                    end else begin
                        next_pair  = 1'b1;
                        state_next = FETCH;
                    end
                end else if (watchdog == WD_LAST) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. The address for the next pair is loaded while still
    // in WAIT so that FETCH presents it to the buffer; the FETCH/ISSUE pair
    // that follows also gives the PE its recovery time after done. The error
    // and abort strobes are registered so they appear in the cycle after the
    // decision, when the FSM is already back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            len_q    <= '0;
            watchdog <= '0;
            mem_addr <= '0;
            result   <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            err_q   <= bad_len | timed_out;
            abort_q <= timed_out;

            if (start_job) begin
                len_q <= len;
            end

            if (empty_job) begin
                result <= '0;
            end else if (final_pair) begin
                result <= pe_result;
            end

            if (state == CLEAR) begin
                idx      <= '0;
                mem_addr <= '0;
            end else if (next_pair) begin
                idx      <= idx + ADDR_W'(1);
                mem_addr <= idx + ADDR_W'(1);
            end

            if (state == ISSUE) begin
                watchdog <= '0;
            end else if (state == WAIT) begin
                watchdog <= watchdog + WD_W'(1);
            end
        end
    end

    // Moore-style outputs decoded from the state, plus the registered strobes.
    // The PE operand lines are forced to zero outside the issue cycle so the
    // PE never sees stale buffer data.
    assign busy         = (state != IDLE);
    assign pe_ready     = (state == ISSUE);
    assign pe_rst       = (state == CLEAR) | abort_q;
    assign result_valid = (state == FINISH);
    assign err          = err_q;
    assign pe_data1     = pe_ready ? a_data : '0;
    assign pe_data2     = pe_ready ? b_data : '0;

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pe_dot_sequencer
// Self-checking bench for pe_dot_sequencer. Provides a synchronous-read
// operand buffer and a behavioural PE (accumulates on ready, pulses done
// PE_LATENCY edges later), runs directed and random jobs and compares the
// observed strobes, timing and result against values derived from the job
// rules: pair cost of 12 cycles, first issue two cycles after CLEAR, result as
// a plain sum of products.
// -----------------------------------------------------------------------------
module tb_pe_dot_sequencer;
    import mmul_pkg::*;

    localparam int DEPTH       = 8;
    localparam int ADDR_W      = 3;
    localparam int TIMEOUT     = 32;
    localparam int PAIR_CYCLES = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              pe_rst;
    logic              pe_ready;
    logic [DATA_W-1:0] pe_data1;
    logic [DATA_W-1:0] pe_data2;
    logic              pe_done = 1'bx;
    logic [ACC_W-1:0]  pe_result;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              err;

    int n_checks = 0;
    int n_fails  = 0;
    int last_result = 0;

    logic signed [7:0] buf_a [DEPTH];
    logic signed [7:0] buf_b [DEPTH];

    logic signed [ACC_W-1:0] pe_acc;
    int                      pe_count = 0;
    int                      pe_prod;
    bit                      pe_hang = 1'b0;

    pe_dot_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .mem_addr(mem_addr), .a_data(a_data), .b_data(b_data),
        .pe_rst(pe_rst), .pe_ready(pe_ready), .pe_data1(pe_data1),
        .pe_data2(pe_data2), .pe_done(pe_done), .pe_result(pe_result),
        .result(result), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read operand buffer: data follows the address by one edge.
    always @(posedge clk) begin
        a_data <= buf_a[mem_addr];
        b_data <= buf_b[mem_addr];
    end

    // Behavioural PE. done stays X until the first issue, then pulses once
    // PE_LATENCY edges after each sampled ready unless the PE is told to hang.
    assign pe_prod   = $signed(pe_data1) * $signed(pe_data2);
    assign pe_result = pe_acc;

    always @(posedge clk) begin
        if (pe_rst) begin
            pe_acc   <= '0;
            pe_count <= 0;
        end else if (pe_ready) begin
            pe_acc   <= pe_acc + pe_prod[ACC_W-1:0];
            pe_count <= PE_LATENCY;
        end else if (pe_count != 0) begin
            pe_count <= pe_count - 1;
        end
        if (pe_ready) begin
            pe_done <= 1'b0;
        end else if (pe_count == 1 && !pe_hang && !pe_rst) begin
            pe_done <= 1'b1;
        end else if (pe_done === 1'b1) begin
            pe_done <= 1'b0;
        end
    end

    // Safety net so the run always ends even if a bounded loop is miscoded.
    initial begin
        #1000000;
        $display("[TB] FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "[TB] time limit");
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Runs one job of job_len pairs from the current buffer contents and
    // checks it against the expectations derived from the job rules.
    // stray_k >= 0 pulses start again in that cycle after acceptance.
    task automatic applyStimulus(input string tag, input int job_len, input int stray_k);
        int exp_sum, exp_end, exp_ready, exp_rst, exp_valid_k, exp_err_k, exp_result;
        int ready_cnt, rst_cnt, valid_cnt, err_cnt, valid_k, err_k;
        int first_ready_k, last_ready_k, bad_spacing, dirty_data, busy_bad, busy_after;
        bit rejected;

        exp_sum = 0;
        for (int i = 0; i < job_len && i < DEPTH; i++) begin
            exp_sum += int'(buf_a[i]) * int'(buf_b[i]);
        end
        exp_ready   = 0;
        exp_rst     = 0;
        exp_valid_k = -1;
        exp_err_k   = -1;
        exp_result  = last_result;
        rejected    = 1'b0;
        if (job_len == 0) begin
            exp_valid_k = 0;
            exp_result  = 0;
            exp_end     = 0;
        end else if (job_len > DEPTH) begin
            exp_err_k = 0;
            exp_end   = 0;
            rejected  = 1'b1;
        end else if (pe_hang) begin
            exp_ready = 1;
            exp_rst   = 2;
            exp_err_k = 3 + TIMEOUT;
            exp_end   = exp_err_k;
        end else begin
            exp_ready   = job_len;
            exp_rst     = 1;
            exp_valid_k = 1 + PAIR_CYCLES * job_len;
            exp_result  = exp_sum;
            exp_end     = exp_valid_k;
        end

        ready_cnt = 0; rst_cnt = 0; valid_cnt = 0; err_cnt = 0;
        valid_k = -1; err_k = -1; first_ready_k = -1; last_ready_k = -1;
        bad_spacing = 0; dirty_data = 0; busy_bad = 0; busy_after = -1;

        @(negedge clk);
        start = 1'b1;
        len   = job_len[ADDR_W:0];
        @(posedge clk);
        for (int k = 0; k <= exp_end + 2; k++) begin
            @(negedge clk);
            start = (k == stray_k);
            if (pe_ready) begin
                ready_cnt++;
                if (ready_cnt == 1) first_ready_k = k;
                else if (k - last_ready_k != PAIR_CYCLES) bad_spacing++;
                last_ready_k = k;
            end else if (pe_data1 !== '0 || pe_data2 !== '0) begin
                dirty_data++;
            end
            if (pe_rst) rst_cnt++;
            if (result_valid) begin valid_cnt++; valid_k = k; end
            if (err) begin err_cnt++; err_k = k; end
            if (rejected) begin
                if (busy !== 1'b0) busy_bad++;
            end else if (k < exp_end && busy !== 1'b1) begin
                busy_bad++;
            end
            if (k == exp_end + 1) busy_after = int'(busy);
        end
        start = 1'b0;

        checkOutput({tag, ".ready_cnt"},   ready_cnt, exp_ready);
        if (exp_ready > 0) checkOutput({tag, ".first_ready_k"}, first_ready_k, 2);
        checkOutput({tag, ".ready_spacing"}, bad_spacing, 0);
        checkOutput({tag, ".data_idle_zero"}, dirty_data, 0);
        checkOutput({tag, ".pe_rst_cnt"},  rst_cnt, exp_rst);
        checkOutput({tag, ".valid_cnt"},   valid_cnt, (exp_valid_k >= 0) ? 1 : 0);
        checkOutput({tag, ".valid_k"},     valid_k, exp_valid_k);
        checkOutput({tag, ".err_cnt"},     err_cnt, (exp_err_k >= 0) ? 1 : 0);
        checkOutput({tag, ".err_k"},       err_k, exp_err_k);
        checkOutput({tag, ".busy_during"}, busy_bad, 0);
        checkOutput({tag, ".busy_after"},  busy_after, 0);
        checkOutput({tag, ".result"},      $signed(result), exp_result);
        last_result = exp_result;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            buf_a[i] = '0;
            buf_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.ctrl", {busy, pe_rst, pe_ready, result_valid, err}, 0);
        checkOutput("reset.mem_addr", mem_addr, 0);
        checkOutput("reset.result", $signed(result), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] job len=3 small positives");
        buf_a[0] = 1; buf_a[1] = 2; buf_a[2] = 3;
        buf_b[0] = 4; buf_b[1] = 5; buf_b[2] = 6;
        applyStimulus("len3", 3, -1);

        $display("[TB] job len=2 extreme operands");
        buf_a[0] = -128; buf_a[1] = 127;
        buf_b[0] = -128; buf_b[1] = -1;
        applyStimulus("len2_ext", 2, -1);

        $display("[TB] job len=8 worst case");
        for (int i = 0; i < DEPTH; i++) begin
            buf_a[i] = -128;
            buf_b[i] = -128;
        end
        applyStimulus("len8_max", 8, -1);

        $display("[TB] empty and oversize jobs");
        applyStimulus("len0", 0, -1);
        applyStimulus("len9", 9, -1);

        $display("[TB] hung PE");
        buf_a[0] = 7; buf_b[0] = 9;
        pe_hang = 1'b1;
        applyStimulus("timeout", 2, -1);
        pe_hang = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] start during WAIT is ignored");
        buf_a[0] = 11; buf_a[1] = -6;
        buf_b[0] = 2;  buf_b[1] = 5;
        applyStimulus("stray_start", 2, 5);

        $display("[TB] reset in the middle of WAIT");
        @(negedge clk);
        start = 1'b1;
        len   = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid.ctrl", {busy, pe_rst, pe_ready, result_valid, err}, 0);
        checkOutput("rst_mid.mem_addr", mem_addr, 0);
        checkOutput("rst_mid.result", $signed(result), 0);
        checkOutput("rst_mid.pe_data", {pe_data1, pe_data2}, 0);
        last_result = 0;
        repeat (15) @(negedge clk);
        buf_a[0] = 3; buf_b[0] = -5;
        applyStimulus("after_rst", 1, -1);

        $display("[TB] random jobs");
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_a[i] = 8'($urandom);
                buf_b[i] = 8'($urandom);
            end
            applyStimulus("random", int'($urandom_range(1, DEPTH)), -1);
        end
        applyStimulus("random_bad", int'($urandom_range(DEPTH + 1, 15)), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pe_dot_sequencer.md
Name: pe_dot_sequencer

Overview:
Controller that sequences one signed 8-bit shift-add processing element through a dot product of up to DEPTH operand pairs. It clears the PE accumulator and fetches operand pairs from a synchronous-read operand buffer. It issues one ready pulse per pair, waits for the PE done pulse, and returns the final accumulated result with a one-cycle valid strobe. It sits between the matrix-multiplier top-level control and each PE instance.

Parameters:
DEPTH, 8, maximum operand pairs per job
ADDR_W, 3, operand buffer address width (clog2 DEPTH)
TIMEOUT, 32, WAIT-state cycles without pe_done before abort

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job request, sampled only in IDLE
len  in  ADDR_W+1  pair count for the job, sampled with start
busy  out  1  high in every state except IDLE
mem_addr  out  ADDR_W  operand buffer read address, registered
a_data  in  8  signed operand A, valid the cycle after mem_addr
b_data  in  8  signed operand B, valid the cycle after mem_addr
pe_rst  out  1  PE reset (clears PE accumulator)
pe_ready  out  1  one-cycle issue strobe to PE
pe_data1  out  8  signed operand to PE; equals a_data while pe_ready, else 0
pe_data2  out  8  signed operand to PE; equals b_data while pe_ready, else 0
pe_done  in  1  PE completion pulse, one cycle
pe_result  in  23  signed PE accumulator
result  out  23  signed latched dot product
result_valid  out  1  one-cycle strobe, result valid
err  out  1  one-cycle strobe: bad len or timeout

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE. idx, watchdog, mem_addr, result and len_q are 0. busy, pe_rst, pe_ready, result_valid and err are 0. Reset mid-job abandons the job with no strobe.
- IDLE: on start=1:
  - len==0: go to FINISH; result <= 0.
  - len>DEPTH: go to IDLE; err=1 next cycle; no PE activity.
  - Otherwise: latch len_q and go to CLEAR.
- start in any non-IDLE state is ignored.
- CLEAR (1 cycle): pe_rst=1, idx<=0, mem_addr<=0. Next state FETCH.
- FETCH (1 cycle): mem_addr=idx; buffer returns data next cycle. Next state ISSUE.
- ISSUE (1 cycle): pe_ready=1; pe_data1/pe_data2 pass a_data/b_data; watchdog<=0. Next state WAIT.
- WAIT:
  - pe_done is sampled only here; outside WAIT it is ignored, including X before the PE's first completion.
  - On pe_done=1 with idx==len_q-1: result<=pe_result; go to FINISH.
  - On pe_done=1 with idx<len_q-1: idx<=idx+1, mem_addr<=idx+1; go to FETCH.
  - The FETCH+ISSUE pair supplies the 2-cycle PE recovery after done, so ready is never presented to a busy PE.
  - If watchdog reaches TIMEOUT-1 without pe_done: err=1 and pe_rst=1 for one cycle; go to IDLE; no result_valid.
- FINISH (1 cycle): result_valid=1. Next state IDLE.
- PE latency is 10 WAIT cycles per pair: done is visible 9 edges after the ready edge. Each pair therefore costs 12 cycles (FETCH+ISSUE+10 WAIT).
- Job latency: start sampled at edge S, so result_valid is high in the cycle after edge S+1+12*len.
  - len=0: result_valid at S+1.
  - len=8: result_valid at S+97.
- Arithmetic: accumulation happens in the PE. The controller only latches pe_result. Worst case 8*(-128*-128)=131072, which fits 23-bit signed; no saturation.
- result holds its value until the next result_valid or rst.
- Back-to-back: start can be accepted in the IDLE cycle directly after FINISH.

Decomposition:
- Shared package mmul_pkg holds:
  - state enum (IDLE, CLEAR, FETCH, ISSUE, WAIT, FINISH)
  - DATA_W=8, ACC_W=23, PE_LATENCY=9
  - default DEPTH and TIMEOUT
- Single flat module; the watchdog counter is inline. No sub-module.

Test Plan:
- len=3, A=[1,2,3], B=[4,5,6] -> pe_rst once, three pe_ready pulses 12 cycles apart, result=32, result_valid at S+37.
- len=2, A=[-128,127], B=[-128,-1] -> result=16257; pe_data1/pe_data2 are 0 outside ISSUE.
- len=8, all operands -128 -> result=131072, result_valid at S+97, busy low the following cycle.
- len=0 -> result=0, result_valid at S+1, no pe_rst/pe_ready. len=9 -> err at S+1, busy stays 0.
- PE model never asserts done -> err and pe_rst pulse when WAIT reaches TIMEOUT cycles, no result_valid, busy drops.
- Stimulus sequence for busy/reset handling:
  - start pulsed during WAIT of job 1 (len=2) -> ignored.
  - rst asserted mid-WAIT -> all outputs 0 next cycle.
  - Fresh job, len=1, A=[3], B=[-5] -> result=-15, showing the PE accumulator was cleared in CLEAR.
